mdu_hilo: RTL and testbench

- Multiply/divide unit with HI/LO registers for the MIPS datapath.
- Sits beside the ALU in the execute stage.
- Its out port is a fourth candidate source for the register-write-data select (mfhi/mflo), next to ALU out, DM read data and PC+4.
- busy is the stall source consumed by the controller.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_calc.sv | 54 +++++
 rtl/mdu_hilo.sv | 88 ++++++++
 tb/tb_mdu_hilo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, HI/LO read select
// and the two-state sequencer encoding.
package mdu_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {hi, lo} from latched operands.
// MDU_DIV0_KEEP_EN: when defined, divide-by-zero deasserts commit so HI/LO keep their value.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        commit
);

  logic        sgn, a_neg, b_neg, div_zero;
  logic [31:0] mag_a, mag_b, div_b, uq, ur;
  logic [63:0] ext_a, ext_b;

  assign sgn      = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg    = sgn & a[31];
  assign b_neg    = sgn & b[31];
  assign ext_a    = {{32{a_neg}}, a};
  assign ext_b    = {{32{b_neg}}, b};
  assign div_zero = (b == 32'd0);

  // Divide on magnitudes and restore signs: quotient truncates toward zero,
  // remainder takes the dividend's sign.
  assign mag_a = a_neg ? (~a + 32'd1) : a;
  assign mag_b = b_neg ? (~b + 32'd1) : b;
  assign div_b = div_zero ? 32'd1 : mag_b;
  assign uq    = mag_a / div_b;
  assign ur    = mag_a % div_b;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result = '0;
    commit = 1'b1;
    case (op)
      MD_MULT, MD_MULTU: result = ext_a * ext_b;
      MD_DIV, MD_DIVU: begin
        if (div_zero) begin
`ifdef MDU_DIV0_KEEP_EN
          commit = 1'b0;
`else
          result = {a, 32'hFFFF_FFFF};
`endif
        end else begin
          result = {(a_neg ? (~ur + 32'd1) : ur),
                    ((a_neg ^ b_neg) ? (~uq + 32'd1) : uq)};
        end
      end
      default: commit = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls the pipeline.
// MDU_DIV0_KEEP_EN (optional): divide-by-zero leaves HI/LO unchanged.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_sel,
  output logic [31:0] out,
  output logic        busy
);

  localparam int CNT_MAX = ((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) - 1;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q, hi, lo;
  logic [63:0]   result;
  logic          commit;

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .commit (commit)
  );

  // Reads always see committed registers, so a running op never leaks a partial result.
  assign out = (hilo_sel == HILO_SEL_HI) ? hi : lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= MD_NOP;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q  <= md_op;
                a_q   <= rs_val;
                b_q   <= rt_val;
                cnt   <= ((md_op == MD_MULT) || (md_op == MD_MULTU))
                         ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                state <= S_RUN;
                busy  <= 1'b1;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            if (commit) begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes expected {hi, lo, busy length},
// a monitor pops and compares on every falling edge of busy.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = MD_NOP;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hilo_sel = HILO_SEL_LO;
  logic [31:0] out;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hilo_sel (hilo_sel),
    .out      (out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    md_op  = MD_NOP;
  endtask

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input int len);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Returns at the first negedge where busy is low.
  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: counts busy cycles and checks HI/LO in the first idle cycle.
  initial begin
    bit prev = 1'b0;
    int cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (busy) begin
          cnt++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_busy_len"}, cnt, e.len);
            hilo_sel = HILO_SEL_LO;
            #1 check({e.name, "_lo"}, out, e.lo);
            hilo_sel = HILO_SEL_HI;
            #1 check({e.name, "_hi"}, out, e.hi);
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    hilo_sel = HILO_SEL_LO;
    #1 check("reset_lo", out, 32'd0);
    hilo_sel = HILO_SEL_HI;
    #1 check("reset_hi", out, 32'd0);

    // MULT -3 * 7 = -21
    @(posedge clk); #1;
    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle("mult");

    // MULTU accepted in the first idle cycle; MTHI while busy must be ignored.
    expect_op("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    hilo_sel = HILO_SEL_LO;
    #1 check("multu_old_lo_while_busy", out, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    wait_idle("multu");

    // DIV -7 / 2 -> q=-3, r=-1
    expect_op("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    expect_op("divu", 32'd1, 32'd3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle("divu");

    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    hilo_sel = HILO_SEL_HI;
    #1 check("mthi_hi", out, 32'h0000_1234);

    @(posedge clk); #1;
    issue(3'b111, 32'hDEAD_BEEF, 32'hBEEF_DEAD);
    @(negedge clk);
    check("reserved_busy", {31'd0, busy}, 32'd0);
    hilo_sel = HILO_SEL_HI;
    #1 check("reserved_hi", out, 32'h0000_1234);
    hilo_sel = HILO_SEL_LO;
    #1 check("reserved_lo", out, 32'd3);

    @(posedge clk); #1;
    issue(MD_MTHI, 32'd5, 32'd0);
    issue(MD_MTLO, 32'd6, 32'd0);
`ifdef MDU_DIV0_KEEP_EN
    expect_op("div0", 32'd5, 32'd6, 10);
`else
    expect_op("div0", 32'd9, 32'hFFFF_FFFF, 10);
`endif
    issue(MD_DIV, 32'd9, 32'd0);
    wait_idle("div0");

    // Reset in the third busy cycle of a MULT aborts it with no write.
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check("abort_busy", {31'd0, busy}, 32'd0);
    hilo_sel = HILO_SEL_LO;
    #1 check("abort_lo", out, 32'd0);
    hilo_sel = HILO_SEL_HI;
    #1 check("abort_hi", out, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
